// File: rtl/xor_reduce_mux_pipe.sv
// Pipelined word-parity engine: a registered tree of mux-based XOR cells plus frame accumulation.
// Define XOR_REDUCE_ODD_PARITY_EN to present odd parity on down_parity and down_frame_parity.
module xor_reduce_mux_pipe #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_parity,
    output logic             down_last,
    output logic             down_frame_parity
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int CW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef XOR_REDUCE_ODD_PARITY_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    // 2:1 mux cell; an XOR of a and b is mux(sel=a, d0=b, d1=~b).
    function automatic logic mux2(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

    logic stall;
    logic tail_valid;
    logic tail_parity;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int OW = WIDTH >> k;

        logic [2*OW-1:0] lvl_in;
        logic [OW-1:0]   red;
        logic [OW-1:0]   data_d;
        logic [OW-1:0]   data_q;
        logic            valid_d;
        logic            valid_q;

        if (k == 1) begin : g_first
            assign lvl_in  = up_data;
            assign valid_d = stall ? valid_q : (up_valid & up_ready);
        end else begin : g_next
            assign lvl_in  = g_lvl[k-1].data_q;
            assign valid_d = stall ? valid_q : g_lvl[k-1].valid_q;
        end

        always_comb begin
            red = '0;
            for (int i = 0; i < OW; i++) begin
                red[i] = mux2(lvl_in[2*i], lvl_in[2*i+1], ~lvl_in[2*i+1]);
            end
        end

        assign data_d = stall ? data_q : red;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    assign tail_valid  = g_lvl[LEVELS].valid_q;
    assign tail_parity = g_lvl[LEVELS].data_q[0];

    // The whole pipe freezes together, so a held output word blocks new input.
    assign stall    = tail_valid & ~down_ready;
    assign up_ready = ~stall;

    logic [CW-1:0] cnt_d, cnt_q;
    logic          acc_d, acc_q;
    logic          is_last;
    logic          xfer;

    assign is_last = (cnt_q == CW'(FRAME_LEN - 1));
    assign xfer    = tail_valid & down_ready;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (xfer) begin
            if (is_last) begin
                cnt_d = '0;
                acc_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = acc_q ^ tail_parity;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // The accumulator holds even parity; any inversion happens only at the outputs.
    assign down_valid        = tail_valid;
    assign down_parity       = tail_valid & (tail_parity ^ PAR_INV);
    assign down_last         = tail_valid & is_last;
    assign down_frame_parity = tail_valid & (acc_q ^ tail_parity ^ PAR_INV);

endmodule

// File: tb/tb_xor_reduce_mux_pipe.sv
// Self-checking bench for xor_reduce_mux_pipe: directed frames, stalls, bubbles, async reset,
// plus random traffic on WIDTH 2/16/32 instances, all scored against a queue-based model.
module tb_xor_reduce_mux_pipe;

`ifdef XOR_REDUCE_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       up_valid;
    logic [7:0] up_data;
    logic       down_ready;
    logic       up_ready;
    logic       down_valid;
    logic       down_parity;
    logic       down_last;
    logic       down_frame_parity;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] log_q[$];
    int         sweep_done = 0;
    logic       end_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- DUTs and per-instance scoreboard ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W   = (gi == 0) ? 8 : (gi == 1) ? 2 : (gi == 2) ? 16 : 32;
        localparam int F   = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 3 : 5;
        localparam int LVL = $clog2(W);

        logic         uv, ur, dv, dr, dp, dl, dfp;
        logic [W-1:0] ud;

        xor_reduce_mux_pipe #(.WIDTH(W), .FRAME_LEN(F)) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .up_valid         (uv),
            .up_ready         (ur),
            .up_data          (ud),
            .down_valid       (dv),
            .down_ready       (dr),
            .down_parity      (dp),
            .down_last        (dl),
            .down_frame_parity(dfp)
        );

        if (gi == 0) begin : g_main
            assign uv                = up_valid;
            assign ud                = up_data;
            assign dr                = down_ready;
            assign up_ready          = ur;
            assign down_valid        = dv;
            assign down_parity       = dp;
            assign down_last         = dl;
            assign down_frame_parity = dfp;
        end else begin : g_rand
            initial begin
                int unsigned r;
                int unsigned r2;
                uv = 1'b0;
                ud = '0;
                dr = 1'b1;
                @(posedge rst_n);
                repeat (600) begin
                    @(posedge clk);
                    #1;
                    r  = $urandom;
                    r2 = $urandom;
                    uv = r[0];
                    dr = (r[2:1] != 2'b00);
                    ud = r2[W-1:0];
                end
                @(posedge clk);
                #1;
                uv = 1'b0;
                dr = 1'b1;
                sweep_done++;
            end
        end

        // Model: accepted words in order; frame = list of parities already sent in it.
        logic [W-1:0] exp_q[$];
        int           acc_cyc_q[$];
        int           acc_stl_q[$];
        bit           fr_q[$];
        int           cyc    = 0;
        int           stalls = 0;
        logic         held   = 1'b0;
        logic [3:0]   prev   = '0;

        always @(negedge rst_n) begin
            exp_q.delete();
            acc_cyc_q.delete();
            acc_stl_q.delete();
            fr_q.delete();
            held = 1'b0;
        end

        always @(negedge clk) begin
            logic [W-1:0] w;
            logic         p, fx, e_last;
            int           t_c, t_s;
            if (rst_n) begin
                if (dv && dr) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("spurious_w%0d", W), 32'(dv), 32'(0));
                    end else begin
                        w   = exp_q.pop_front();
                        t_c = acc_cyc_q.pop_front();
                        t_s = acc_stl_q.pop_front();
                        p   = 1'b0;
                        for (int i = 0; i < W; i++) p = p ^ w[i];
                        fx = p;
                        foreach (fr_q[i]) fx = fx ^ fr_q[i];
                        e_last = (fr_q.size() == F - 1);
                        chk($sformatf("parity_w%0d", W), 32'(dp), 32'(p ^ ODD));
                        chk($sformatf("frame_par_w%0d", W), 32'(dfp), 32'(fx ^ ODD));
                        chk($sformatf("last_w%0d", W), 32'(dl), 32'(e_last));
                        chk($sformatf("latency_w%0d", W), 32'(cyc - t_c), 32'(LVL + stalls - t_s));
                        if (e_last) fr_q.delete();
                        else fr_q.push_back(p);
                        if (gi == 0) log_q.push_back({dl, dfp, dp});
                    end
                end
                if (!dv) begin
                    chk($sformatf("idle_last_w%0d", W), 32'(dl), 32'(0));
                    chk($sformatf("idle_frame_w%0d", W), 32'(dfp), 32'(0));
                end
                chk($sformatf("up_ready_w%0d", W), 32'(ur), 32'(!(dv && !dr)));
                if (held) chk($sformatf("hold_w%0d", W), 32'({dv, dp, dl, dfp}), 32'(prev));
                held = dv && !dr;
                prev = {dv, dp, dl, dfp};
                if (dv && !dr) stalls++;
                if (uv && ur) begin
                    exp_q.push_back(ud);
                    acc_cyc_q.push_back(cyc);
                    acc_stl_q.push_back(stalls);
                end
                cyc++;
            end
        end

        initial begin
            wait (end_chk);
            chk($sformatf("drain_w%0d", W), 32'(exp_q.size()), 32'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] w);
        int guard;
        guard    = 0;
        up_valid = 1'b1;
        up_data  = w;
        @(negedge clk);
        while (!up_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!up_ready) chk("send_timeout", 32'(up_ready), 32'(1));
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic drain();
        down_ready = 1'b1;
        up_valid   = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_last_pattern(input string tag, input logic [3:0] e_last);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(4));
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk(tag, 32'(log_q[i][2]), 32'(e_last[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] t1_w[4];
        logic [7:0] t2_w[8];
        logic [3:0] e_par, e_frm, e_last;
        int         g;
        t1_w = '{8'hA5, 8'h01, 8'h07, 8'hFF};
        t2_w = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03, 8'h03, 8'h80};
        e_par  = 4'b0110;
        e_frm  = 4'b0010;
        e_last = 4'b1000;

        up_valid   = 1'b0;
        up_data    = '0;
        down_ready = 1'b1;

        #1;
        chk("rst_valid", 32'(down_valid), 32'(0));
        chk("rst_parity", 32'(down_parity), 32'(0));
        chk("rst_last", 32'(down_last), 32'(0));
        chk("rst_frame", 32'(down_frame_parity), 32'(0));
        chk("rst_up_ready", 32'(up_ready), 32'(1));
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back single frame
        log_q.delete();
        for (int i = 0; i < 4; i++) send(t1_w[i]);
        drain();
        chk("t1_count", 32'(log_q.size()), 32'(4));
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_parity", 32'(log_q[i][0]), 32'(e_par[i] ^ ODD));
                chk("t1_frame", 32'(log_q[i][1]), 32'(e_frm[i] ^ ODD));
                chk("t1_last", 32'(log_q[i][2]), 32'(e_last[i]));
            end
        end

        // two frames, accumulator restarts
        log_q.delete();
        for (int i = 0; i < 8; i++) send(t2_w[i]);
        drain();
        chk("t2_count", 32'(log_q.size()), 32'(8));
        if (log_q.size() == 8) begin
            chk("t2_end1", 32'(log_q[3][2:1]), 32'({1'b1, 1'b1 ^ ODD}));
            chk("t2_end2", 32'(log_q[7][2:1]), 32'({1'b1, 1'b1 ^ ODD}));
        end

        // output held for 5 cycles while more input is offered
        log_q.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        fork
            begin
                send(8'h44);
                send(8'h55);
            end
            begin
                g = 0;
                while (!down_valid && g < 20) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                chk("stall_reach", 32'(down_valid), 32'(1));
                down_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                down_ready = 1'b1;
            end
        join
        send(8'h66);
        send(8'h77);
        send(8'h88);
        drain();
        chk("stall_count", 32'(log_q.size()), 32'(8));

        // bubbles between words do not advance the frame
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom));
            @(posedge clk);
            #1;
        end
        drain();
        check_last_pattern("bubble_last", 4'b1000);

        // async reset mid-frame with a word held at the output
        send(8'h5A);
        send(8'h3C);
        drain();
        down_ready = 1'b0;
        send(8'hC3);
        repeat (4) @(posedge clk);
        chk("pre_rst_valid", 32'(down_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(down_valid), 32'(0));
        chk("mid_rst_parity", 32'(down_parity), 32'(0));
        chk("mid_rst_last", 32'(down_last), 32'(0));
        chk("mid_rst_frame", 32'(down_frame_parity), 32'(0));
        chk("mid_rst_up_ready", 32'(up_ready), 32'(1));
        #1;
        rst_n      = 1'b1;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        log_q.delete();
        for (int i = 0; i < 4; i++) send(8'($urandom));
        drain();
        check_last_pattern("post_rst_last", 4'b1000);

        // random valid/ready traffic on the main instance
        repeat (300) begin
            @(posedge clk);
            #1;
            up_valid   = 1'($urandom_range(0, 1));
            up_data    = 8'($urandom);
            down_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        g = 0;
        while (sweep_done < 3 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        chk("sweep_done", 32'(sweep_done), 32'(3));
        drain();

        end_chk = 1'b1;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xor_reduce_mux_pipe.md
Name: xor_reduce_mux_pipe

Overview:
- Pipelined, parametrised XOR-reduction (word parity) engine built only from 2:1 `mux` cells, constants and wires; every 2-input XOR is a mux with sel=a, d0=b, d1=~b.
- Accepts WIDTH-bit words on a valid/ready stream and emits per-word parity after a log2(WIDTH)-level registered mux tree.
- Accumulates parity across frames of FRAME_LEN words and flags the last word of each frame.
- Sits between a byte/word source and a link-layer checker as the parity front end.

Parameters:
- WIDTH, 8, input word width; power of two, >= 2.
- FRAME_LEN, 4, output words per frame; >= 1.
- LEVELS, $clog2(WIDTH), derived localparam (not overridable); number of tree levels and pipeline stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- up_valid  input  1  source has a word.
- up_ready  output  1  block accepts the word this cycle.
- up_data  input  WIDTH  word to reduce.
- down_valid  output  1  result available.
- down_ready  input  1  sink accepts the result.
- down_parity  output  1  XOR of all WIDTH bits of the word.
- down_last  output  1  word is the FRAME_LEN-th word of its frame.
- down_frame_parity  output  1  XOR of the parities of all words in the frame up to and including this one.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all stage data = 0, frame counter = 0, accumulator = 0.
- Outputs during reset: down_valid = 0, down_parity = 0, down_last = 0, down_frame_parity = 0, up_ready = 1.
- Tree structure:
  - Level k reduces its WIDTH>>(k-1) inputs pairwise into WIDTH>>k bits using mux-XOR cells.
  - A register follows every level: LEVELS stages in total, each with its own valid bit.
- Global stall: stall = down_valid & ~down_ready. up_ready = ~stall (combinational).
  - When stall = 1, no stage register or valid bit updates.
  - When stall = 0, every stage advances by one. Stage 1 captures up_valid & up_ready together with the level-1 result.
- Latency: a word transferred in cycle c appears with down_valid = 1 in cycle c + LEVELS, when no stall occurs in between. Throughput is 1 word/cycle.
- Stream order is preserved. Bubbles (up_valid = 0) propagate as invalid stages. Data in invalid stages is don't-care and must not affect the frame logic.
- Frame logic acts only on output transfers (down_valid & down_ready):
  - A counter cnt runs 0..FRAME_LEN-1. down_last = down_valid & (cnt == FRAME_LEN-1).
  - Accumulator acc: down_frame_parity = acc ^ down_parity, gated by down_valid.
  - On a transfer with down_last = 1: cnt -> 0 and acc -> 0.
  - On any other transfer: cnt -> cnt+1 and acc -> acc ^ down_parity.
- FRAME_LEN = 1: down_last = 1 on every valid word, and down_frame_parity = down_parity.
- Holding: while down_valid & ~down_ready, down_parity, down_last and down_frame_parity hold stable.
- Simultaneous events: in a cycle with both an output transfer and an input transfer, both happen and the pipeline shifts normally.
- Reset mid-frame or mid-pipeline: all in-flight words are dropped and the frame restarts at cnt = 0. There is no partial-frame output.

Optional Feature:
- Macro: XOR_REDUCE_ODD_PARITY_EN.
- Defined: down_parity and down_frame_parity carry odd parity (both XNOR of their inputs, i.e. inverted). The accumulator still stores even parity internally, and the inversion is applied at the outputs only. Outputs remain 0 while down_valid = 0 and during reset.
- Undefined: even parity exactly as described above.

Test Plan:
- WIDTH=8, FRAME_LEN=4; words 0xA5, 0x01, 0x07, 0xFF sent back-to-back with down_ready = 1 -> first down_valid 3 cycles after the first transfer.
  - down_parity = 0, 1, 1, 0.
  - down_frame_parity = 0, 1, 0, 0.
  - down_last only on 0xFF.
- Two frames 0x01, 0x00, 0x00, 0x00, then 0x03, 0x03, 0x03, 0x80 -> first frame ends with down_frame_parity = 1 and down_last = 1. Second frame restarts from 0 and ends with down_frame_parity = 1.
- down_ready held low 5 cycles while a word is at the output -> up_ready = 0 during the hold, outputs stable, no words lost or duplicated, order preserved after release.
- up_valid toggling 1, 0, 1, 0 -> bubbles do not advance cnt. down_last appears on the 4th real word only.
- rst_n pulsed low asynchronously (mid-cycle) after 2 words of a frame -> outputs go to 0 immediately. The next 4 words form a full frame with down_last on the 4th.
- With XOR_REDUCE_ODD_PARITY_EN, words 0xA5, 0x01, 0x07, 0xFF -> down_parity = 1, 0, 0, 1 and final down_frame_parity = 1.
- Sweep WIDTH in {2, 16, 32} with random data -> down_parity matches ^data, and latency equals $clog2(WIDTH).
